pipelined_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter for the ALU datapath. Supports SLL, SRA, SRL
//  and ROR on a WIDTH-bit operand. The log2(WIDTH) shift levels are split across STAGES

---
 rtl/pipelined_shifter_pkg.sv | 23 ++
 rtl/pipelined_shifter_if.sv | 27 ++
 rtl/pipelined_shifter_stage.sv | 73 +++++++
 rtl/pipelined_shifter.sv | 68 ++++++
 tb/tb_pipelined_shifter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipelined_shifter_pkg.sv
// Opcode encodings and the per-op control tag that travels with shifter data.
package shifter_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_SLL = 5'b00100,
    OP_SRA = 5'b00101,
    OP_SRL = 5'b00110,
    OP_ROR = 5'b00111
  } shift_op_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic             sign;
  } shift_tag_t;

  // All four shift opcodes share the 001xx prefix.
  function automatic logic is_shift_op(input logic [OPC_W-1:0] op);
    return op[4:2] == 3'b001;
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle between the ALU operand muxes and the shifter.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shift_ctrl;
  logic [4:0]         ctrl_ALUopcode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic               data_zero;

  modport master (
    output in_valid, data_in, shift_ctrl, ctrl_ALUopcode, out_ready,
    input  in_ready, out_valid, data_out, data_zero
  );

  modport slave (
    input  in_valid, data_in, shift_ctrl, ctrl_ALUopcode, out_ready,
    output in_ready, out_valid, data_out, data_zero
  );

endinterface

// File: rtl/pipelined_shifter_stage.sv
// One pipeline stage: N_LEVELS shift-by-2^k muxes starting at LO_LEVEL, then a
// valid/ready payload register that advances when empty or downstream is ready.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LO_LEVEL = 0,
  parameter int N_LEVELS = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  input  shift_tag_t               i_tag,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(WIDTH)-1:0] o_shamt,
  output shift_tag_t               o_tag
);
  localparam int SHAMT_W = $clog2(WIDTH);

  // n is always a power of two in 1..WIDTH/2, so WIDTH-n never reaches 0 or WIDTH.
  function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d,
                                                   input int n, input shift_tag_t t);
    case (t.opcode)
      OP_SLL:  level_shift = d << n;
      OP_SRL:  level_shift = d >> n;
      OP_SRA:  level_shift = (d >> n) | ({WIDTH{t.sign}} << (WIDTH - n));
      OP_ROR:  level_shift = (d >> n) | (d << (WIDTH - n));
      default: level_shift = d;
    endcase
  endfunction

  logic [N_LEVELS:0][WIDTH-1:0] w_lvl;
  logic                         w_adv;

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_shamt;
  shift_tag_t         r_tag;

  assign w_lvl[0] = i_data;
  for (genvar k = 0; k < N_LEVELS; k++) begin : g_lvl
    assign w_lvl[k+1] = i_shamt[LO_LEVEL+k] ? level_shift(w_lvl[k], 1 << (LO_LEVEL + k), i_tag)
                                            : w_lvl[k];
  end

  assign w_adv = !r_valid | i_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_tag   <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= w_lvl[N_LEVELS];
        r_shamt <= i_shamt;
        r_tag   <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRA/SRL/ROR); log2(WIDTH) levels spread over STAGES
// registered stages with full-throughput valid/ready back-pressure.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic                clock,
  input logic                reset_n,
  pipelined_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LPS     = (SHAMT_W + STAGES - 1) / STAGES;

  // Index 0 is the input boundary, index s+1 is the output register of stage s.
  logic       [STAGES:0]              w_vld_pipe;
  logic       [STAGES:0]              w_rdy_pipe;
  logic       [STAGES:0][WIDTH-1:0]   w_data;
  logic       [STAGES:0][SHAMT_W-1:0] w_shamt;
  shift_tag_t [STAGES:0]              w_tag;
  logic                               w_op_ok;

  // Unknown opcodes enter as zero data with no sign, so every level leaves them zero.
  assign w_op_ok          = is_shift_op(bus.ctrl_ALUopcode);
  assign w_vld_pipe[0]    = bus.in_valid;
  assign w_data[0]        = w_op_ok ? bus.data_in : '0;
  assign w_shamt[0]       = bus.shift_ctrl;
  assign w_tag[0].opcode  = bus.ctrl_ALUopcode;
  assign w_tag[0].sign    = w_op_ok & bus.data_in[WIDTH-1];

  assign w_rdy_pipe[STAGES] = bus.out_ready;
  assign bus.in_ready       = w_rdy_pipe[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = (s * LPS < SHAMT_W) ? s * LPS : SHAMT_W;
    localparam int HI = ((s + 1) * LPS < SHAMT_W) ? (s + 1) * LPS : SHAMT_W;

    // Unrolled form of ready_s = !valid_s | ready_{s+1}: any empty slot downstream frees stage s.
    assign w_rdy_pipe[s] = bus.out_ready | ~&w_vld_pipe[STAGES:s+1];

    shift_stage #(
      .WIDTH    (WIDTH),
      .LO_LEVEL (LO),
      .N_LEVELS (HI - LO)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_valid (w_vld_pipe[s]),
      .i_data  (w_data[s]),
      .i_shamt (w_shamt[s]),
      .i_tag   (w_tag[s]),
      .i_ready (w_rdy_pipe[s+1]),
      .o_valid (w_vld_pipe[s+1]),
      .o_data  (w_data[s+1]),
      .o_shamt (w_shamt[s+1]),
      .o_tag   (w_tag[s+1])
    );
  end

  assign bus.out_valid = w_vld_pipe[STAGES];
  assign bus.data_out  = w_data[STAGES];
  assign bus.data_zero = w_vld_pipe[STAGES] & ~|w_data[STAGES];

  logic w_unused;
  assign w_unused = ^{w_shamt[STAGES], w_tag[STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboarded bench: three shifters (STAGES 2, 1, 5) share one stimulus stream.
`timescale 1ns/1ps
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int W = 32;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [31:0] data_in = '0;
  logic [4:0] shift_ctrl = '0;
  logic [4:0] opcode = '0;

  int cyc = 0;
  bit lat_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int t; bit lat; } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                        input logic [4:0] op);
    case (op)
      OP_SLL:  return d << sh;
      OP_SRL:  return d >> sh;
      OP_SRA:  return $signed(d) >>> sh;
      OP_ROR:  return (sh == 5'd0) ? d : ((d >> sh) | (d << (6'd32 - {1'b0, sh})));
      default: return 32'h0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    pipelined_shifter_if #(.WIDTH(W)) bif ();
    exp_t q[$];
    int   n_out = 0;

    assign bif.in_valid       = in_valid;
    assign bif.data_in        = data_in;
    assign bif.shift_ctrl     = shift_ctrl;
    assign bif.ctrl_ALUopcode = opcode;
    assign bif.out_ready      = out_ready;

    pipelined_shifter #(.WIDTH(W), .STAGES(ST)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bif.slave)
    );

    always @(negedge clock) begin
      exp_t e;
      if (bif.out_valid && bif.out_ready) begin
        n_out++;
        if (q.size() == 0) check($sformatf("s%0d_unexpected_out", ST), q.size(), 1);
        else begin
          e = q.pop_front();
          check($sformatf("s%0d_data", ST), bif.data_out, e.d);
          check($sformatf("s%0d_zero", ST), 32'(bif.data_zero), 32'(e.d == 32'h0));
          if (e.lat) check($sformatf("s%0d_latency", ST), cyc - e.t, ST);
        end
      end
      if (bif.in_valid && bif.in_ready)
        q.push_back('{model(data_in, shift_ctrl, opcode), cyc, lat_en});
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] d, input logic [4:0] sh);
    int n = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; opcode = op; data_in = d; shift_ctrl = sh;
    @(negedge clock);
    while (!g_dut[0].bif.in_ready && n < 50) begin @(negedge clock); n++; end
    check("send_accept", 32'(g_dut[0].bif.in_ready), 32'd1);
  endtask

  task automatic drain();
    @(posedge clock); #1 in_valid = 1'b0;
    for (int n = 0; n < 100 && (g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()) != 0; n++)
      @(negedge clock);
    @(negedge clock);
    check("drain_q_s2", g_dut[0].q.size(), 0);
    check("drain_q_s1", g_dut[1].q.size(), 0);
    check("drain_q_s5", g_dut[2].q.size(), 0);
  endtask

  logic [4:0]  t_op [8] = '{OP_SLL, OP_SRA, OP_SRL, OP_SRA, OP_ROR, OP_ROR, OP_SLL, OP_SRA};
  logic [31:0] t_d  [8] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                            32'h0000_00F1, 32'h1234_5678, 32'hA5A5_A5A5, 32'h7FFF_FFFF};
  logic [4:0]  t_sh [8] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd4, 5'd0, 5'd0, 5'd31};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] hold;
    int          i, base;

    @(posedge clock); #1;
    check("rst_out_valid", 32'(g_dut[0].bif.out_valid), 32'd0);
    check("rst_data_out",  g_dut[0].bif.data_out, 32'h0);
    check("rst_data_zero", 32'(g_dut[0].bif.data_zero), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 32'(g_dut[0].bif.in_ready), 32'd1);

    lat_en = 1'b1;
    for (int k = 0; k < 8; k++) send(t_op[k], t_d[k], t_sh[k]);
    for (int k = 0; k < 16; k++)
      send((k % 5 == 4) ? 5'($urandom) : {3'b001, 2'($urandom)}, $urandom, 5'($urandom));
    drain();
    lat_en = 1'b0;

    // Back-pressure: out_ready low for iterations 2..4 while six ops stream in.
    i = 0;
    base = g_dut[0].n_out;
    hold = '0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (i < 6);
      opcode    = t_op[i % 8];
      data_in   = t_d[i % 8] ^ 32'(i);
      shift_ctrl = t_sh[i % 8] ^ 5'(i);
      @(negedge clock);
      if (c == 2) begin
        hold = g_dut[0].bif.data_out;
        check("stall_out_valid", 32'(g_dut[0].bif.out_valid), 32'd1);
      end
      if (c == 3 || c == 4) begin
        check("stall_in_ready", 32'(g_dut[0].bif.in_ready), 32'd0);
        check("stall_hold_data", g_dut[0].bif.data_out, hold);
        check("stall_hold_valid", 32'(g_dut[0].bif.out_valid), 32'd1);
      end
      if (in_valid && g_dut[0].bif.in_ready) i++;
    end
    drain();
    check("stall_result_count", g_dut[0].n_out - base, 6);

    lat_en = 1'b1;
    send(5'b00000, 32'hDEAD_BEEF, 5'd3);
    send(5'b01100, 32'hFFFF_FFFF, 5'd0);
    drain();

    // Asynchronous reset with two ops in flight.
    send(OP_SLL, 32'h0000_0001, 5'd1);
    send(OP_ROR, 32'h0000_0003, 5'd1);
    @(posedge clock); #1 in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid_s2", 32'(g_dut[0].bif.out_valid), 32'd0);
    check("arst_out_valid_s5", 32'(g_dut[2].bif.out_valid), 32'd0);
    check("arst_data_out",     g_dut[0].bif.data_out, 32'h0);
    check("arst_data_zero",    32'(g_dut[0].bif.data_zero), 32'd0);
    g_dut[0].q.delete();
    g_dut[1].q.delete();
    g_dut[2].q.delete();
    base = g_dut[0].n_out + g_dut[1].n_out + g_dut[2].n_out;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("arst_rel_in_ready", 32'(g_dut[0].bif.in_ready), 32'd1);
    repeat (10) @(negedge clock);
    check("arst_no_stale", g_dut[0].n_out + g_dut[1].n_out + g_dut[2].n_out - base, 0);

    send(OP_SRA, 32'h8000_0000, 5'd4);
    send(OP_SRL, 32'h8000_0000, 5'd4);
    send(OP_SLL, 32'hFFFF_FFFF, 5'd31);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
